bht_ctrl: RTL and testbench
===========================

Name: bht_ctrl

Overview:
- Controller and arbiter for a single-ported branch history table (BHT).
- Each BHT entry is a 2-bit saturating counter.
- Sits between the fetch stage (prediction lookups) and the execute stage (resolved-branch updates).
- Sequences table initialisation after reset/flush, arbitrates the single table port between init, lookup and update, and buffers updates in a small FIFO when lookups occupy the port.

Parameters:
IDX_W, 6, table index width; table holds 2^IDX_W counters
PC_W, 32, program counter width
UQ_DEPTH, 4, update queue depth in entries; power of 2, >=2

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush_i  in  1  re-initialise table, discard queued updates
lookup_valid_i  in  1  fetch requests a prediction
lookup_pc_i  in  PC_W  PC of branch to predict
lookup_ready_o  out  1  lookup accepted this cycle when high with lookup_valid_i
lookup_vld_o  out  1  lookup_pred_o valid this cycle
lookup_pred_o  out  1  1 = predict taken, 0 = predict not taken
upd_valid_i  in  1  resolved branch outcome available
upd_pc_i  in  PC_W  PC of resolved branch
upd_taken_i  in  1  actual outcome, 1 = taken
upd_ready_o  out  1  update enqueued when high with upd_valid_i
upd_pending_o  out  1  update queue non-empty
busy_o  out  1  table initialisation in progress

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
- Reset values:
  - FSM enters INIT with init_ptr = 0 and the queue empty.
  - busy_o = 1; lookup_ready_o = 0; upd_ready_o = 0.
  - lookup_vld_o = 0; lookup_pred_o = 0; upd_pending_o = 0.
- Index = pc[IDX_W+1:2] for both lookup and update; aliasing is permitted.
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.
  - Prediction = counter MSB.
  - Update with taken: increment, saturating at 11.
  - Update with not-taken: decrement, saturating at 00.
- FSM INIT:
  - Each cycle writes 2'b10 to entry init_ptr, then init_ptr increments.
  - After writing entry 2^IDX_W-1, the FSM moves to RUN. INIT lasts exactly 2^IDX_W cycles.
  - busy_o = 1 throughout; lookup_ready_o = upd_ready_o = 0.
- FSM RUN:
  - busy_o = 0.
  - flush_i = 1 in RUN goes to INIT next cycle with init_ptr = 0, queue emptied, and no drain that cycle.
  - flush_i = 1 during INIT restarts init_ptr at 0.
- Port arbitration in RUN, one table access per cycle, by priority:
  1. Queue full: the head update drains; lookup_ready_o = 0.
  2. Otherwise lookup_valid_i: the lookup reads the table; lookup_ready_o = 1.
  3. Otherwise queue non-empty: the head update drains.
- Lookup latency 1:
  - A lookup accepted at cycle t gives lookup_vld_o = 1 at t+1.
  - lookup_pred_o at t+1 is the MSB of the counter value at t.
  - lookup_vld_o = 0 otherwise; lookup_pred_o holds its last value.
- Drain: read-modify-write completes at the clock edge ending the drain cycle; a lookup in the next cycle observes the new value.
- Queued (undrained) updates are not forwarded to lookups.
- Queue:
  - upd_ready_o = RUN && !full.
  - A drain and an enqueue may occur in the same cycle when the queue is not full.
  - No enqueue while full, even on a drain cycle.
  - upd_pending_o = !empty.
  - FIFO order is strict.
  - Pointers wrap modulo UQ_DEPTH; occupancy counter is log2(UQ_DEPTH)+1 bits.
- Reset mid-operation: everything returns to reset values immediately; queued updates are lost.
- lookup_vld_o = 0 on the cycle after a flush is asserted.

Test Plan:
- Reset release, IDX_W=6 -> busy_o=1 for exactly 64 cycles, ready outputs 0. Then lookup pc 0x0000_0040 -> lookup_vld_o next cycle, pred=1.
- Two not-taken updates pc 0x100, no lookups -> drained on consecutive cycles, upd_pending_o=0. Lookup 0x100 -> pred 0; lookup 0x104 -> pred 1.
- Saturation on pc 0x10:
  - 5 taken updates then 1 not-taken -> pred 1.
  - Then 4 not-taken -> pred 0.
  - Then 1 taken -> pred 0.
- Lookups every cycle plus 4 updates:
  - Queue fills and upd_ready_o=0.
  - Next cycle lookup_ready_o=0 and one update drains.
  - Following cycle lookup_ready_o=1, upd_ready_o=1.
  - All 4 updates eventually applied in order.
- flush_i in RUN with 3 queued updates -> queue empty next cycle, busy_o=1 for 64 cycles, all lookups then pred 1.
- reset_n low mid-drain with queue non-empty -> outputs immediately at reset values, INIT restarts, no stale update applied.

Source files
------------

// File: rtl/bht_ctrl.sv
// Branch history table controller: sequences table init, arbitrates the single
// table port between init, fetch lookups and queued execute-stage updates.
module bht_ctrl #(
  parameter int IDX_W    = 6,
  parameter int PC_W     = 32,
  parameter int UQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            lookup_valid_i,
  input  logic [PC_W-1:0] lookup_pc_i,
  output logic            lookup_ready_o,
  output logic            lookup_vld_o,
  output logic            lookup_pred_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  output logic            upd_ready_o,
  output logic            upd_pending_o,
  output logic            busy_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = $clog2(UQ_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             lookup_vld_q, lookup_vld_d;
  logic             lookup_pred_q, lookup_pred_d;

  logic [1:0]       bht_mem      [ENTRIES];
  logic [IDX_W-1:0] uq_idx_mem   [UQ_DEPTH];
  logic             uq_taken_mem [UQ_DEPTH];

  logic             run;
  logic             full;
  logic             empty;
  logic             lookup_fire;
  logic             drain;
  logic             enq;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [1:0]       head_ctr;
  logic [1:0]       head_ctr_next;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [1:0]       mem_wdata;
  logic             unused_pc;

  assign lookup_idx = lookup_pc_i[IDX_W+1:2];
  assign upd_idx    = upd_pc_i[IDX_W+1:2];
  assign unused_pc  = ^{lookup_pc_i[PC_W-1:IDX_W+2], lookup_pc_i[1:0],
                        upd_pc_i[PC_W-1:IDX_W+2], upd_pc_i[1:0]};

  assign run   = (state_q == ST_RUN);
  assign full  = (count_q == CNT_W'(UQ_DEPTH));
  assign empty = (count_q == '0);

  assign lookup_ready_o = run && !full;
  assign upd_ready_o    = run && !full;
  assign upd_pending_o  = !empty;
  assign busy_o         = (state_q == ST_INIT);
  assign lookup_vld_o   = lookup_vld_q;
  assign lookup_pred_o  = lookup_pred_q;

  // A full queue steals the port from fetch so updates can never starve.
  assign lookup_fire = lookup_valid_i && lookup_ready_o;
  assign drain       = run && !flush_i && !empty && (full || !lookup_valid_i);
  assign enq         = upd_valid_i && upd_ready_o && !flush_i;

  assign head_idx   = uq_idx_mem[head_q];
  assign head_taken = uq_taken_mem[head_q];
  assign head_ctr   = bht_mem[head_idx];

  always_comb begin
    head_ctr_next = head_ctr;
    if (head_taken) begin
      if (head_ctr != 2'b11) head_ctr_next = head_ctr + 2'd1;
    end else begin
      if (head_ctr != 2'b00) head_ctr_next = head_ctr - 2'd1;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = head_idx;
    mem_wdata = head_ctr_next;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_ptr_q;
      mem_wdata = 2'b10;
    end else if (drain) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    init_ptr_d    = init_ptr_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    lookup_vld_d  = lookup_fire && !flush_i;
    lookup_pred_d = lookup_pred_q;

    if (lookup_fire && !flush_i) lookup_pred_d = bht_mem[lookup_idx][1];

    case (state_q)
      ST_INIT: begin
        if (flush_i) begin
          init_ptr_d = '0;
        end else begin
          init_ptr_d = init_ptr_q + IDX_W'(1);
          if (init_ptr_q == IDX_W'(ENTRIES - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d    = ST_INIT;
          init_ptr_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq)   tail_d = tail_q + PTR_W'(1);
      if (drain) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_INIT;
      init_ptr_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      lookup_vld_q  <= 1'b0;
      lookup_pred_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      lookup_vld_q  <= lookup_vld_d;
      lookup_pred_q <= lookup_pred_d;
    end
  end

  // Storage arrays carry no reset; INIT rewrites the whole table instead.
  always_ff @(posedge clk) begin
    if (mem_we) bht_mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      uq_idx_mem[tail_q]   <= upd_idx;
      uq_taken_mem[tail_q] <= upd_taken_i;
    end
  end

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed self-checking bench for bht_ctrl: init timing, prediction, saturation,
// queue arbitration under lookup pressure, flush and asynchronous reset.
module tb_bht_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_i;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        lookup_ready_o;
  logic        lookup_vld_o;
  logic        lookup_pred_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        upd_ready_o;
  logic        upd_pending_o;
  logic        busy_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit stall    = 1'b0;
  bit ready_bad;

  bht_ctrl #(.IDX_W(6), .PC_W(32), .UQ_DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush_i        (flush_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_pc_i    (lookup_pc_i),
    .lookup_ready_o (lookup_ready_o),
    .lookup_vld_o   (lookup_vld_o),
    .lookup_pred_o  (lookup_pred_o),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_ready_o    (upd_ready_o),
    .upd_pending_o  (upd_pending_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    ready_bad = 1'b0;
    while (busy_o === 1'b1 && n < 200) begin
      if (lookup_ready_o !== 1'b0 || upd_ready_o !== 1'b0) ready_bad = 1'b1;
      n++;
      tick();
    end
  endtask

  task automatic do_lookup(input logic [31:0] pc, output logic vld, output logic pred);
    int n = 0;
    lookup_pc_i    = pc;
    lookup_valid_i = 1'b1;
    while (lookup_ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    lookup_valid_i = 1'b0;
    vld  = (n >= 50) ? 1'bx : lookup_vld_o;
    pred = lookup_pred_o;
    $display("lookup pc=%h vld=%b pred=%b", pc, vld, pred);
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk);
    int n = 0;
    upd_pc_i    = pc;
    upd_taken_i = tk;
    upd_valid_i = 1'b1;
    while (upd_ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) stall = 1'b1;
    tick();
    upd_valid_i = 1'b0;
    $display("update pc=%h taken=%b", pc, tk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (upd_pending_o !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) stall = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    logic v, p;
    reset_n        = 1'b0;
    flush_i        = 1'b0;
    lookup_valid_i = 1'b0;
    lookup_pc_i    = '0;
    upd_valid_i    = 1'b0;
    upd_pc_i       = '0;
    upd_taken_i    = 1'b0;
    repeat (3) tick();
    chk_cnt++; if (busy_o !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy_o); else pass_cnt++;
    chk_cnt++; if (lookup_ready_o !== 1'b0) $display("FAIL reset_lookup_ready got=%b exp=0", lookup_ready_o); else pass_cnt++;
    chk_cnt++; if (upd_ready_o !== 1'b0) $display("FAIL reset_upd_ready got=%b exp=0", upd_ready_o); else pass_cnt++;
    chk_cnt++; if (lookup_vld_o !== 1'b0) $display("FAIL reset_vld got=%b exp=0", lookup_vld_o); else pass_cnt++;
    chk_cnt++; if (lookup_pred_o !== 1'b0) $display("FAIL reset_pred got=%b exp=0", lookup_pred_o); else pass_cnt++;
    chk_cnt++; if (upd_pending_o !== 1'b0) $display("FAIL reset_pending got=%b exp=0", upd_pending_o); else pass_cnt++;
    reset_n = 1'b1;
    count_busy(n);
    chk_cnt++; if (n != 64) $display("FAIL init_busy_cycles got=%0d exp=64", n); else pass_cnt++;
    chk_cnt++; if (ready_bad !== 1'b0) $display("FAIL init_ready_low got=%b exp=0", ready_bad); else pass_cnt++;
    do_lookup(32'h0000_0040, v, p);
    chk_cnt++; if (v !== 1'b1) $display("FAIL first_lookup_vld got=%b exp=1", v); else pass_cnt++;
    chk_cnt++; if (p !== 1'b1) $display("FAIL first_lookup_pred got=%b exp=1", p); else pass_cnt++;
    tick();
    chk_cnt++; if (lookup_vld_o !== 1'b0) $display("FAIL vld_one_cycle got=%b exp=0", lookup_vld_o); else pass_cnt++;
  endtask

  task automatic test_drain();
    logic v, p;
    upd_pc_i    = 32'h100;
    upd_taken_i = 1'b0;
    upd_valid_i = 1'b1;
    tick();
    chk_cnt++; if (upd_pending_o !== 1'b1) $display("FAIL drain_pending_1 got=%b exp=1", upd_pending_o); else pass_cnt++;
    tick();
    upd_valid_i = 1'b0;
    chk_cnt++; if (upd_pending_o !== 1'b1) $display("FAIL drain_pending_2 got=%b exp=1", upd_pending_o); else pass_cnt++;
    tick();
    chk_cnt++; if (upd_pending_o !== 1'b0) $display("FAIL drain_pending_3 got=%b exp=0", upd_pending_o); else pass_cnt++;
    do_lookup(32'h100, v, p);
    chk_cnt++; if (p !== 1'b0 || v !== 1'b1) $display("FAIL drain_pred_100 got=%b vld=%b exp=0", p, v); else pass_cnt++;
    do_lookup(32'h104, v, p);
    chk_cnt++; if (p !== 1'b1 || v !== 1'b1) $display("FAIL drain_pred_104 got=%b vld=%b exp=1", p, v); else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic v, p;
    for (int i = 0; i < 5; i++) do_update(32'h10, 1'b1);
    do_update(32'h10, 1'b0);
    wait_drain();
    do_lookup(32'h10, v, p);
    chk_cnt++; if (p !== 1'b1 || v !== 1'b1) $display("FAIL sat_high got=%b vld=%b exp=1", p, v); else pass_cnt++;
    for (int i = 0; i < 4; i++) do_update(32'h10, 1'b0);
    wait_drain();
    do_lookup(32'h10, v, p);
    chk_cnt++; if (p !== 1'b0 || v !== 1'b1) $display("FAIL sat_low got=%b vld=%b exp=0", p, v); else pass_cnt++;
    do_update(32'h10, 1'b1);
    wait_drain();
    do_lookup(32'h10, v, p);
    chk_cnt++; if (p !== 1'b0 || v !== 1'b1) $display("FAIL sat_one_up got=%b vld=%b exp=0", p, v); else pass_cnt++;
    do_update(32'h10, 1'b1);
    wait_drain();
    do_lookup(32'h10, v, p);
    chk_cnt++; if (p !== 1'b1 || v !== 1'b1) $display("FAIL sat_two_up got=%b vld=%b exp=1", p, v); else pass_cnt++;
    chk_cnt++; if (stall !== 1'b0) $display("FAIL sat_no_stall got=%b exp=0", stall); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit tk [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic v, p;
    lookup_pc_i    = 32'h80;
    lookup_valid_i = 1'b1;
    upd_pc_i       = 32'h20;
    upd_valid_i    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      upd_taken_i = tk[i];
      tick();
    end
    upd_valid_i = 1'b0;
    chk_cnt++; if (upd_ready_o !== 1'b0) $display("FAIL b2b_full_upd_ready got=%b exp=0", upd_ready_o); else pass_cnt++;
    chk_cnt++; if (lookup_ready_o !== 1'b0) $display("FAIL b2b_full_lookup_ready got=%b exp=0", lookup_ready_o); else pass_cnt++;
    chk_cnt++; if (lookup_vld_o !== 1'b1) $display("FAIL b2b_vld_before got=%b exp=1", lookup_vld_o); else pass_cnt++;
    tick();
    chk_cnt++; if (lookup_ready_o !== 1'b1) $display("FAIL b2b_after_lookup_ready got=%b exp=1", lookup_ready_o); else pass_cnt++;
    chk_cnt++; if (upd_ready_o !== 1'b1) $display("FAIL b2b_after_upd_ready got=%b exp=1", upd_ready_o); else pass_cnt++;
    chk_cnt++; if (lookup_vld_o !== 1'b0) $display("FAIL b2b_vld_stolen got=%b exp=0", lookup_vld_o); else pass_cnt++;
    chk_cnt++; if (upd_pending_o !== 1'b1) $display("FAIL b2b_pending got=%b exp=1", upd_pending_o); else pass_cnt++;
    lookup_valid_i = 1'b0;
    wait_drain();
    do_lookup(32'h20, v, p);
    chk_cnt++; if (p !== 1'b0 || v !== 1'b1) $display("FAIL b2b_order_pred got=%b vld=%b exp=0", p, v); else pass_cnt++;
    chk_cnt++; if (stall !== 1'b0) $display("FAIL b2b_no_stall got=%b exp=0", stall); else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [31:0] pcs [4] = '{32'h30, 32'h100, 32'h10, 32'h20};
    int n;
    logic v, p;
    lookup_pc_i    = 32'h80;
    lookup_valid_i = 1'b1;
    upd_pc_i       = 32'h30;
    upd_taken_i    = 1'b0;
    upd_valid_i    = 1'b1;
    repeat (3) tick();
    upd_valid_i = 1'b0;
    chk_cnt++; if (upd_pending_o !== 1'b1) $display("FAIL flush_pre_pending got=%b exp=1", upd_pending_o); else pass_cnt++;
    flush_i = 1'b1;
    tick();
    flush_i        = 1'b0;
    lookup_valid_i = 1'b0;
    chk_cnt++; if (upd_pending_o !== 1'b0) $display("FAIL flush_pending got=%b exp=0", upd_pending_o); else pass_cnt++;
    chk_cnt++; if (lookup_vld_o !== 1'b0) $display("FAIL flush_vld got=%b exp=0", lookup_vld_o); else pass_cnt++;
    count_busy(n);
    chk_cnt++; if (n != 64) $display("FAIL flush_busy_cycles got=%0d exp=64", n); else pass_cnt++;
    chk_cnt++; if (ready_bad !== 1'b0) $display("FAIL flush_ready_low got=%b exp=0", ready_bad); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      do_lookup(pcs[i], v, p);
      chk_cnt++; if (p !== 1'b1 || v !== 1'b1) $display("FAIL flush_pred pc=%h got=%b vld=%b exp=1", pcs[i], p, v); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic v, p;
    lookup_pc_i    = 32'h80;
    lookup_valid_i = 1'b1;
    upd_pc_i       = 32'h30;
    upd_taken_i    = 1'b0;
    upd_valid_i    = 1'b1;
    repeat (3) tick();
    upd_valid_i    = 1'b0;
    lookup_valid_i = 1'b0;
    chk_cnt++; if (lookup_pred_o !== 1'b1) $display("FAIL mid_pre_pred got=%b exp=1", lookup_pred_o); else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    chk_cnt++; if (busy_o !== 1'b1) $display("FAIL mid_busy got=%b exp=1", busy_o); else pass_cnt++;
    chk_cnt++; if (lookup_ready_o !== 1'b0 || upd_ready_o !== 1'b0) $display("FAIL mid_ready got=%b%b exp=00", lookup_ready_o, upd_ready_o); else pass_cnt++;
    chk_cnt++; if (lookup_vld_o !== 1'b0) $display("FAIL mid_vld got=%b exp=0", lookup_vld_o); else pass_cnt++;
    chk_cnt++; if (lookup_pred_o !== 1'b0) $display("FAIL mid_pred got=%b exp=0", lookup_pred_o); else pass_cnt++;
    chk_cnt++; if (upd_pending_o !== 1'b0) $display("FAIL mid_pending got=%b exp=0", upd_pending_o); else pass_cnt++;
    repeat (2) tick();
    reset_n = 1'b1;
    count_busy(n);
    chk_cnt++; if (n != 64) $display("FAIL mid_busy_cycles got=%0d exp=64", n); else pass_cnt++;
    do_lookup(32'h30, v, p);
    chk_cnt++; if (p !== 1'b1 || v !== 1'b1) $display("FAIL mid_no_stale got=%b vld=%b exp=1", p, v); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_drain();
    test_saturation();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
